// File: rtl/uart_tx_serializer_if.sv
// Parallel-side bundle of the UART transmit serializer: request, frame config,
// external parity calculator loop and serial outputs.
interface uart_tx_serializer_if #(
  parameter int DataWIDTH = 3
);
  localparam int W = 2 ** DataWIDTH;

  logic [W-1:0] UartTx_PDATA;
  logic         UartTx_DataValid;
  logic         UartTx_ParEn;
  logic         UartTx_ParType;
  logic [W-1:0] UartTx_ParData;
  logic         UartTx_ParTypeLat;
  logic         UartTx_ParBit;
  logic         UartTx_TxOut;
  logic         UartTx_Busy;

  // master: the data source plus the parity calculator
  modport master (
    output UartTx_PDATA, UartTx_DataValid, UartTx_ParEn, UartTx_ParType, UartTx_ParBit,
    input  UartTx_ParData, UartTx_ParTypeLat, UartTx_TxOut, UartTx_Busy
  );

  modport slave (
    input  UartTx_PDATA, UartTx_DataValid, UartTx_ParEn, UartTx_ParType, UartTx_ParBit,
    output UartTx_ParData, UartTx_ParTypeLat, UartTx_TxOut, UartTx_Busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit.
// Define UART_TX_STOP2_EN to append a second stop bit to every frame.
module uart_tx_serializer #(
  parameter int DataWIDTH = 3
) (
  input logic                 UartTx_CLK,
  input logic                 UartTx_RST,
  uart_tx_serializer_if.slave bus
);

  // state  | meaning
  // IDLE   | line high, waiting for DataValid
  // START  | start bit (0)
  // DATA   | data bits, LSB first
  // PARITY | parity bit from the external calculator
  // STOP   | stop bit (1)
  // STOP2  | second stop bit (UART_TX_STOP2_EN only)

  localparam int W = 2 ** DataWIDTH;
  localparam logic [DataWIDTH-1:0] CNT_LAST = DataWIDTH'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_TX_STOP2_EN
    , S_STOP2 = 3'd5
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [DataWIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [W-1:0]         data_q, data_d;
  logic                 ptype_q, ptype_d;
  logic                 paren_q, paren_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge UartTx_CLK or posedge UartTx_RST) begin
    if (UartTx_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      ptype_q <= 1'b0;
      paren_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ptype_q <= ptype_d;
      paren_q <= paren_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // tx_d/busy_d describe the state being entered, so the line is registered
  // and the start bit appears the cycle after DataValid is sampled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ptype_d = ptype_q;
    paren_d = paren_q;
    tx_d    = 1'b1;
    busy_d  = 1'b1;
    cnt_nxt = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.UartTx_DataValid) begin
          state_d = S_START;
          data_d  = bus.UartTx_PDATA;
          ptype_d = bus.UartTx_ParType;
          paren_d = bus.UartTx_ParEn;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (paren_q) begin
            state_d = S_PARITY;
            tx_d    = bus.UartTx_ParBit;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_nxt;
          tx_d  = data_q[cnt_nxt];
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
`ifdef UART_TX_STOP2_EN
        state_d = S_STOP2;
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
`endif
      end
`ifdef UART_TX_STOP2_EN
      S_STOP2: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.UartTx_ParData    = data_q;
  assign bus.UartTx_ParTypeLat = ptype_q;
  assign bus.UartTx_TxOut      = tx_q;
  assign bus.UartTx_Busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed frame table, reset and
// back-to-back sequences, then random frames against a bit-list reference model.
module tb_uart_tx_serializer;
  localparam int DW = 3;

`ifdef UART_TX_STOP2_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_tx_serializer_if #(.DataWIDTH(DW)) bus ();

  uart_tx_serializer #(.DataWIDTH(DW)) dut (
    .UartTx_CLK (clk),
    .UartTx_RST (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // external parity calculator: even -> XOR of data, odd -> inverted
  assign bus.UartTx_ParBit = (^bus.UartTx_ParData) ^ bus.UartTx_ParTypeLat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  data;
    bit          pe;
    bit          pt;
    bit          disturb;
    logic [12:0] exp;
    int          len;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: frame as a plain bit list, bit i is the line level in frame cycle i.
  function automatic void model(input logic [7:0] d, input bit pe, input bit pt,
                                output logic [12:0] e, output int len);
    e = '0;
    len = 0;
    e[len] = 1'b0; len++;
    for (int k = 0; k < 8; k++) begin
      e[len] = d[k]; len++;
    end
    if (pe) begin
      e[len] = 1'((($countones(d)) + int'(pt)) % 2); len++;
    end
    e[len] = 1'b1; len++;
  endfunction

  task automatic start_frame(input logic [7:0] d, input bit pe, input bit pt, input bit hold);
    bus.UartTx_PDATA     = d;
    bus.UartTx_ParEn     = pe;
    bus.UartTx_ParType   = pt;
    bus.UartTx_DataValid = 1'b1;
    @(negedge clk);
    if (!hold) begin
      bus.UartTx_DataValid = 1'b0;
      bus.UartTx_PDATA     = 8'($urandom);
      bus.UartTx_ParEn     = 1'($urandom);
      bus.UartTx_ParType   = 1'($urandom);
    end
  endtask

  // Called at the negedge of frame cycle 0; returns at the negedge of the idle cycle.
  task automatic check_frame(input logic [7:0] d, input bit pt, input logic [12:0] exp,
                             input int len, input bit disturb, input string tag);
    logic e;
    for (int i = 0; i < len + EXTRA; i++) begin
      e = (i < len) ? exp[i] : 1'b1;
      chk($sformatf("%s tx[%0d]", tag, i), bus.UartTx_TxOut, e);
      chk($sformatf("%s busy[%0d]", tag, i), bus.UartTx_Busy, 1'b1);
      chk($sformatf("%s pardata[%0d]", tag, i), bus.UartTx_ParData, d);
      chk($sformatf("%s partype[%0d]", tag, i), bus.UartTx_ParTypeLat, pt);
      if (disturb) begin
        if (i >= 2 && i <= 5) begin
          bus.UartTx_PDATA     = 8'hFF;
          bus.UartTx_ParEn     = 1'b0;
          bus.UartTx_ParType   = ~pt;
          bus.UartTx_DataValid = 1'b1;
        end else begin
          bus.UartTx_DataValid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk($sformatf("%s idle tx", tag), bus.UartTx_TxOut, 1'b1);
    chk($sformatf("%s idle busy", tag), bus.UartTx_Busy, 1'b0);
  endtask

  initial begin
    logic [12:0] e;
    int          len;
    logic [7:0]  d;
    bit          pe, pt;
    int          gap;

    // expected line levels, bit i = frame cycle i (second stop bit added when enabled)
    tbl[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, disturb: 1'b0, exp: 13'h054A, len: 11};
    tbl[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, disturb: 1'b0, exp: 13'h074A, len: 11};
    tbl[2] = '{data: 8'h00, pe: 1'b0, pt: 1'b0, disturb: 1'b0, exp: 13'h0200, len: 10};
    tbl[3] = '{data: 8'h0F, pe: 1'b1, pt: 1'b0, disturb: 1'b1, exp: 13'h041E, len: 11};

    rst = 1'b1;
    bus.UartTx_PDATA     = '0;
    bus.UartTx_DataValid = 1'b0;
    bus.UartTx_ParEn     = 1'b0;
    bus.UartTx_ParType   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset tx", bus.UartTx_TxOut, 1'b1);
    chk("reset busy", bus.UartTx_Busy, 1'b0);
    chk("reset pardata", bus.UartTx_ParData, 8'h00);
    chk("reset partype", bus.UartTx_ParTypeLat, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle tx", bus.UartTx_TxOut, 1'b1);
    chk("idle busy", bus.UartTx_Busy, 1'b0);

    for (int v = 0; v < 4; v++) begin
      start_frame(tbl[v].data, tbl[v].pe, tbl[v].pt, 1'b0);
      check_frame(tbl[v].data, tbl[v].pt, tbl[v].exp, tbl[v].len, tbl[v].disturb,
                  $sformatf("vec%0d", v));
    end

    // reset asserted between clock edges during the 4th data bit
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre-reset tx", bus.UartTx_TxOut, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async reset tx", bus.UartTx_TxOut, 1'b1);
    chk("async reset busy", bus.UartTx_Busy, 1'b0);
    chk("async reset pardata", bus.UartTx_ParData, 8'h00);
    chk("async reset partype", bus.UartTx_ParTypeLat, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset idle tx", bus.UartTx_TxOut, 1'b1);
    model(8'h3C, 1'b1, 1'b1, e, len);
    start_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check_frame(8'h3C, 1'b1, e, len, 1'b0, "after-reset");

    // DataValid held high: exactly one idle cycle between frames
    model(8'h81, 1'b0, 1'b0, e, len);
    start_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check_frame(8'h81, 1'b0, e, len, 1'b0, "b2b-1");
    @(negedge clk);
    check_frame(8'h81, 1'b0, e, len, 1'b0, "b2b-2");
    bus.UartTx_DataValid = 1'b0;
    @(negedge clk);
    chk("b2b end tx", bus.UartTx_TxOut, 1'b1);
    chk("b2b end busy", bus.UartTx_Busy, 1'b0);

    for (int r = 0; r < 24; r++) begin
      d   = 8'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      gap = $urandom_range(0, 2);
      model(d, pe, pt, e, len);
      start_frame(d, pe, pt, 1'b0);
      check_frame(d, pt, e, len, 1'b0, $sformatf("rnd%0d", r));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk($sformatf("rnd%0d gap tx", r), bus.UartTx_TxOut, 1'b1);
        chk($sformatf("rnd%0d gap busy", r), bus.UartTx_Busy, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter: DataWIDTH, default 3, log2 of the frame data width (data width W = 2**DataWIDTH = 8).
REQ-002 Port: UartTx_CLK  in  1  single clock, one serial bit period per cycle.
REQ-003 Port: UartTx_RST  in  1  reset, asynchronous, active-high.
REQ-004 Port: UartTx_PDATA  in  W  parallel data to transmit.
REQ-005 Port: UartTx_DataValid  in  1  PDATA valid request.
REQ-006 Port: UartTx_ParEn  in  1  parity bit included in frame when 1.
REQ-007 Port: UartTx_ParType  in  1  0 = even, 1 = odd.
REQ-008 Port: UartTx_ParData  out  W  latched frame data, driven to the parity calculator.
REQ-009 Port: UartTx_ParTypeLat  out  1  latched parity type, driven to the parity calculator.
REQ-010 Port: UartTx_ParBit  in  1  parity bit returned by the parity calculator (combinational on ParData/ParTypeLat).
REQ-011 Port: UartTx_TxOut  out  1  serial line, idle high.
REQ-012 Port: UartTx_Busy  out  1  high while a frame is in flight.

Function
REQ-013 TxOut and Busy SHALL be registered outputs.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP (plus STOP2 per REQ-027).
REQ-015 In IDLE: TxOut=1, Busy=0; DataValid=1 at a rising edge SHALL latch PDATA into ParData, ParEn and ParType into internal/ParTypeLat registers, and move to START.
REQ-016 Latency: DataValid sampled in cycle N SHALL produce the start bit (TxOut=0) and Busy=1 in cycle N+1.
REQ-017 START lasts 1 cycle, then DATA.
REQ-018 DATA SHALL emit ParData bits LSB first, one per cycle, W cycles, tracked by a DataWIDTH-bit counter that wraps from W-1 to 0 on exit.
REQ-019 After DATA: PARITY if latched ParEn=1, else STOP.
REQ-020 PARITY SHALL emit UartTx_ParBit for 1 cycle, then STOP.
REQ-021 STOP SHALL emit 1 for 1 cycle with Busy=1, then IDLE (Busy=0, TxOut=1 the following cycle).
REQ-022 DataValid, PDATA, ParEn, ParType SHALL be ignored while not in IDLE; ParData/ParTypeLat SHALL hold stable for the whole frame.
REQ-023 Frame length SHALL be 1+W+ParEn+1 cycles (10 or 11 for W=8); back-to-back frames are separated by at least one IDLE cycle.
REQ-024 DataValid held high continuously SHALL start a new frame on each IDLE cycle (one IDLE cycle between frames).

Reset
REQ-025 Asserting UartTx_RST at any time, including mid-frame, SHALL immediately force state=IDLE, TxOut=1, Busy=0, bit counter=0, ParData=0, ParTypeLat=0, latched ParEn=0.
REQ-026 After reset release, the first rising edge with DataValid=1 SHALL start a frame per REQ-016.

Configuration
REQ-027 Macro UART_TX_STOP2_EN: when defined, STOP is followed by STOP2 (TxOut=1, Busy=1, 1 cycle) giving 11/12-cycle frames; when undefined, STOP2 does not exist and frames are 10/11 cycles.

Verification
REQ-028 PDATA=0xA5, ParEn=1, ParType=0, pulse DataValid -> TxOut sequence 0,1,0,1,0,0,1,0,1,0,1 then idle 1; Busy high exactly 11 cycles.
REQ-029 PDATA=0xA5, ParEn=1, ParType=1 -> parity slot = 1, rest as REQ-028.
REQ-030 PDATA=0x00, ParEn=0 -> TxOut 0 for 9 cycles, then 1; Busy high 10 cycles; no parity slot.
REQ-031 Change PDATA to 0xFF and pulse DataValid during DATA of a 0x0F frame -> transmitted bits remain 0x0F, ParData stays 0x0F until IDLE.
REQ-032 Assert RST during the 4th data bit -> TxOut=1 and Busy=0 asynchronously, without waiting for a clock edge; next DataValid produces a complete, correct frame.
REQ-033 With UART_TX_STOP2_EN defined, PDATA=0x55, ParEn=1 -> 12-cycle frame ending with two 1 stop bits.
